// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box tables, lookup helpers and legal parameter bounds for the
// multi-lane substitution engine.
package aes_sbox_pkg;

    localparam int LANES_MIN  = 1;
    localparam int LANES_MAX  = 32;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 2;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] value);
        return SBOX[value];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] value);
        return INV_SBOX[value];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// Single-byte combinational substitution; inv selects the inverse table.
module aes_sbox_lane
    import aes_sbox_pkg::*;
(
    input  logic [7:0] value,
    input  logic       inv,
    output logic [7:0] result
);

    assign result = inv ? sbox_inv(value) : sbox_fwd(value);

endmodule

// File: rtl/aes_sbox_array.sv
// Multi-lane pipelined AES S-box engine with valid/ready on both sides and a
// per-beat forward/inverse select carried alongside the data.
module aes_sbox_array
    import aes_sbox_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv
);

    localparam int W = 8 * LANES;

    if (LANES < LANES_MIN || LANES > LANES_MAX) begin : g_bad_lanes
        $error("aes_sbox_array: LANES must lie in 1..32");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("aes_sbox_array: STAGES must be 1 or 2");
    end

    logic [W-1:0] lane_src;
    logic [W-1:0] lane_res;
    logic         lane_inv;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox_lane u_lane (
            .value  (lane_src[8*i +: 8]),
            .inv    (lane_inv),
            .result (lane_res[8*i +: 8])
        );
    end

    if (STAGES == 2) begin : g_two
        logic         vld_p0;
        logic         vld_p1;
        logic         inv_p0;
        logic         inv_p1;
        logic [W-1:0] d_p0;
        logic [W-1:0] d_p1;
        logic         rdy_p0;
        logic         rdy_p1;

        assign rdy_p1   = out_ready || !vld_p1;
        assign rdy_p0   = rdy_p1 || !vld_p0;
        assign in_ready = rdy_p0;

        // p0: raw input capture; lookup happens between p0 and p1
        assign lane_src = d_p0;
        assign lane_inv = inv_p0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
                inv_p0 <= 1'b0;
                inv_p1 <= 1'b0;
                d_p0   <= '0;
                d_p1   <= '0;
            end else begin
                if (rdy_p0) begin
                    vld_p0 <= in_valid;
                    if (in_valid) begin
                        d_p0   <= in_data;
                        inv_p0 <= in_inv;
                    end
                end
                // p1: substituted bytes, drives the outputs directly
                if (rdy_p1) begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        d_p1   <= lane_res;
                        inv_p1 <= inv_p0;
                    end
                end
            end
        end

        assign out_valid = vld_p1;
        assign out_data  = d_p1;
        assign out_inv   = inv_p1;
    end else begin : g_one
        logic         vld_p0;
        logic         inv_p0;
        logic [W-1:0] d_p0;
        logic         rdy_p0;

        assign rdy_p0   = out_ready || !vld_p0;
        assign in_ready = rdy_p0;

        // p0: lookup is combinational from the input into the only register
        assign lane_src = in_data;
        assign lane_inv = in_inv;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p0 <= 1'b0;
                inv_p0 <= 1'b0;
                d_p0   <= '0;
            end else if (rdy_p0) begin
                vld_p0 <= in_valid;
                if (in_valid) begin
                    d_p0   <= lane_res;
                    inv_p0 <= in_inv;
                end
            end
        end

        assign out_valid = vld_p0;
        assign out_data  = d_p0;
        assign out_inv   = inv_p0;
    end

endmodule

// File: tb/tb_aes_sbox_array.sv
// Directed bench for aes_sbox_array: a 16-lane two-stage instance and a
// 16-lane single-stage instance checked against an arithmetic AES S-box model.
module tb_aes_sbox_array;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
    logic [127:0] in_data, out_data;
    logic         s1_in_valid, s1_in_ready, s1_in_inv, s1_out_valid, s1_out_ready, s1_out_inv;
    logic [127:0] s1_in_data, s1_out_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   ref_fwd [256];
    logic [7:0]   ref_inv [256];
    logic [127:0] src_d [128];
    logic         src_i [128];
    logic [127:0] got_d [128];
    logic         got_i [128];
    int got_n, cyc_n, block_at, first_acc, last_pop;

    always #5 clk = ~clk;

    aes_sbox_array #(.LANES(16), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv)
    );

    aes_sbox_array #(.LANES(16), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .in_data(s1_in_data), .in_inv(s1_in_inv), .out_valid(s1_out_valid),
        .out_ready(s1_out_ready), .out_data(s1_out_data), .out_inv(s1_out_inv)
    );

    // Reference: multiplicative inverse in GF(2^8) followed by the AES affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_model();
        logic [7:0] x, r, s;
        for (int v = 0; v < 256; v++) begin
            x = v[7:0];
            r = 8'h01;
            for (int k = 0; k < 254; k++) r = gmul(r, x);
            s = r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
            ref_fwd[v] = s;
            ref_inv[s] = x;
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = inv ? ref_inv[d[8*i +: 8]] : ref_fwd[d[8*i +: 8]];
        return r;
    endfunction

    // One clock: drive at the falling edge, observe 1ns later, advance.
    task automatic cyc(input bit sel, input logic v, input logic [127:0] d, input logic inv,
                       input logic ordy, output logic acc, output logic pop,
                       output logic [127:0] pd, output logic pinv);
        if (!sel) begin
            in_valid = v; in_data = d; in_inv = inv; out_ready = ordy;
        end else begin
            s1_in_valid = v; s1_in_data = d; s1_in_inv = inv; s1_out_ready = ordy;
        end
        #1;
        if (!sel) begin
            acc = in_valid && in_ready; pop = out_valid && out_ready;
            pd = out_data; pinv = out_inv;
        end else begin
            acc = s1_in_valid && s1_in_ready; pop = s1_out_valid && s1_out_ready;
            pd = s1_out_data; pinv = s1_out_inv;
        end
        @(negedge clk);
    endtask

    task automatic stream(input bit sel, input int n, input int stall, input int budget);
        int sent;
        logic acc, pop, pinv;
        logic [127:0] pd;
        sent = 0; got_n = 0; cyc_n = 0; block_at = -1; first_acc = -1; last_pop = -1;
        while (got_n < n && cyc_n < budget) begin
            if (sent < n) cyc(sel, 1'b1, src_d[sent], src_i[sent], cyc_n >= stall, acc, pop, pd, pinv);
            else          cyc(sel, 1'b0, '0, 1'b0, cyc_n >= stall, acc, pop, pd, pinv);
            if (sent < n && !acc && block_at < 0) block_at = sent;
            if (acc) begin
                if (first_acc < 0) first_acc = cyc_n;
                sent++;
            end
            if (pop && got_n < 128) begin
                got_d[got_n] = pd; got_i[got_n] = pinv; got_n++; last_pop = cyc_n;
            end
            cyc_n++;
        end
        in_valid = 1'b0; s1_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        in_valid = 0; in_data = '0; in_inv = 0; out_ready = 1;
        s1_in_valid = 0; s1_in_data = '0; s1_in_inv = 0; s1_out_ready = 1;
        #1 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_inv !== 1'b0) begin failures++; $display("FAIL reset_out_inv got=%b exp=0", out_inv); end
        checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("FAIL reset_s1_out_valid got=%b exp=0", s1_out_valid); end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) begin
                rst_n = 1'b0;
                #1;
            end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 128'h0) begin
                failures++;
                $display("FAIL idle_outputs cycle=%0d got rdy=%b vld=%b data=%h exp rdy=1 vld=0 data=0",
                         c, in_ready, out_valid, out_data);
            end
            if (c == 2) rst_n = 1'b1;
        end
    endtask

    task automatic test_forward();
        logic [127:0] d, exp_d;
        logic acc, pop, pinv;
        logic [127:0] pd;
        d = '0;
        d[7:0] = 8'h00; d[15:8] = 8'h01; d[23:16] = 8'h53; d[31:24] = 8'hff;
        for (int i = 4; i < 16; i++) d[8*i +: 8] = 8'(i * 16);
        exp_d = ref_sub(d, 1'b0);
        cyc(1'b0, 1'b1, d, 1'b0, 1'b0, acc, pop, pd, pinv);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL fwd_accept got=%b exp=1", acc); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fwd_latency_early got=%b exp=0", out_valid); end
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, acc, pop, pd, pinv);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fwd_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data[31:0] !== 32'h16ed7c63) begin failures++; $display("FAIL fwd_lanes0_3 got=%h exp=16ed7c63", out_data[31:0]); end
        checks++; if (out_data !== exp_d) begin failures++; $display("FAIL fwd_all_lanes got=%h exp=%h", out_data, exp_d); end
        checks++; if (out_inv !== 1'b0) begin failures++; $display("FAIL fwd_out_inv got=%b exp=0", out_inv); end
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, acc, pop, pd, pinv);
        checks++; if (pop !== 1'b1) begin failures++; $display("FAIL fwd_pop got=%b exp=1", pop); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fwd_drained got=%b exp=0", out_valid); end
        checks++; if (out_data !== exp_d) begin failures++; $display("FAIL fwd_hold_data got=%h exp=%h", out_data, exp_d); end
    endtask

    task automatic test_roundtrip();
        logic [127:0] orig [16];
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) orig[b][8*i +: 8] = 8'(b * 16 + i);
            src_d[b] = orig[b]; src_i[b] = 1'b0;
        end
        stream(1'b0, 16, 0, 200);
        checks++; if (got_n !== 16) begin failures++; $display("FAIL rt_fwd_count got=%0d exp=16", got_n); end
        for (int b = 0; b < 16; b++) begin
            checks++;
            if (got_d[b] !== ref_sub(orig[b], 1'b0) || got_i[b] !== 1'b0) begin
                failures++;
                $display("FAIL rt_fwd beat=%0d got=%h/%b exp=%h/0", b, got_d[b], got_i[b], ref_sub(orig[b], 1'b0));
            end
            src_d[b] = got_d[b]; src_i[b] = 1'b1;
        end
        stream(1'b0, 16, 0, 200);
        checks++; if (got_n !== 16) begin failures++; $display("FAIL rt_inv_count got=%0d exp=16", got_n); end
        for (int b = 0; b < 16; b++) begin
            checks++;
            if (got_d[b] !== orig[b] || got_i[b] !== 1'b1) begin
                failures++;
                $display("FAIL rt_inv beat=%0d got=%h/%b exp=%h/1", b, got_d[b], got_i[b], orig[b]);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int b = 0; b < 8; b++) begin
            src_d[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
            src_i[b] = b[0];
        end
        stream(1'b0, 8, 5, 200);
        checks++; if (block_at !== 2) begin failures++; $display("FAIL bp_block_point got=%0d exp=2", block_at); end
        checks++; if (got_n !== 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got_n); end
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (got_d[b] !== ref_sub(src_d[b], src_i[b]) || got_i[b] !== src_i[b]) begin
                failures++;
                $display("FAIL bp_beat beat=%0d got=%h/%b exp=%h/%b", b, got_d[b], got_i[b],
                         ref_sub(src_d[b], src_i[b]), src_i[b]);
            end
        end
    endtask

    task automatic test_back_to_back(input bit sel, input int exp_span);
        int bad;
        for (int b = 0; b < 100; b++) begin
            src_d[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
            src_i[b] = 1'($urandom_range(0, 1));
        end
        stream(sel, 100, 0, 400);
        checks++; if (got_n !== 100) begin failures++; $display("FAIL b2b_count sel=%0d got=%0d exp=100", sel, got_n); end
        checks++;
        if (last_pop - first_acc !== exp_span) begin
            failures++;
            $display("FAIL b2b_cycles sel=%0d got=%0d exp=%0d", sel, last_pop - first_acc, exp_span);
        end
        bad = 0;
        for (int b = 0; b < 100; b++) begin
            checks++;
            if (got_d[b] !== ref_sub(src_d[b], src_i[b]) || got_i[b] !== src_i[b]) begin
                failures++;
                if (bad < 4) $display("FAIL b2b_beat sel=%0d beat=%0d got=%h/%b exp=%h/%b", sel, b,
                                      got_d[b], got_i[b], ref_sub(src_d[b], src_i[b]), src_i[b]);
                bad++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic acc, pop, pinv;
        logic [127:0] pd;
        cyc(1'b0, 1'b1, 128'h0123456789abcdef_fedcba9876543210, 1'b0, 1'b0, acc, pop, pd, pinv);
        cyc(1'b0, 1'b1, 128'h00112233445566778899aabbccddeeff, 1'b1, 1'b0, acc, pop, pd, pinv);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_full_valid got=%b exp=1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_full_ready got=%b exp=0", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 128'h0 || out_inv !== 1'b0) begin failures++; $display("FAIL rst_async_data got=%h/%b exp=0/0", out_data, out_inv); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, acc, pop, pd, pinv);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_no_stale cycle=%0d got=%b exp=0", c, out_valid); end
        end
        src_d[0] = 128'hdeadbeef_cafef00d_01234567_89abcdef; src_i[0] = 1'b1;
        stream(1'b0, 1, 0, 20);
        checks++; if (got_n !== 1) begin failures++; $display("FAIL rst_after_count got=%0d exp=1", got_n); end
        checks++;
        if (got_d[0] !== ref_sub(src_d[0], 1'b1) || got_i[0] !== 1'b1) begin
            failures++;
            $display("FAIL rst_after_beat got=%h/%b exp=%h/1", got_d[0], got_i[0], ref_sub(src_d[0], 1'b1));
        end
        checks++; if (last_pop - first_acc !== 2) begin failures++; $display("FAIL rst_after_latency got=%0d exp=2", last_pop - first_acc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        build_model();
        test_reset();
        test_forward();
        test_roundtrip();
        test_backpressure();
        test_back_to_back(1'b0, 101);
        test_back_to_back(1'b1, 100);
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_sbox_array.md
# aes_sbox_array

Parametrised, pipelined multi-lane AES S-box engine for the SNOW-V datapath. It substitutes LANES bytes per beat through either the forward or the inverse AES S-box, with the direction selected per beat. It uses valid/ready handshakes on both sides, so the FSM and AES-round logic can feed it back-to-back or stall it. It replaces per-byte combinational S-box instances in the round logic with a registered, throughput-1 block.

## Interface
- LANES, 16, number of byte lanes per beat (1..32)
- STAGES, 2, pipeline depth (legal values 1 or 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat this cycle
- in_data  in  8*LANES  input bytes; lane i = in_data[8i+7:8i]
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box, for this beat
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts beat
- out_data  out  8*LANES  substituted bytes, lane order preserved
- out_inv  out  1  in_inv of the beat, carried alongside it

## Operation
- Transfer on either side happens when valid && ready in the same cycle.
- Each lane is independent: out byte i = SBOX[in byte i] when in_inv=0, and INV_SBOX[in byte i] when in_inv=1.
  - SBOX is the FIPS-197 table, e.g. 00→63, 01→7c, 53→ed, ff→16.
  - INV_SBOX is its exact inverse.
- STAGES=2:
  - Stage 1 registers in_data and in_inv.
  - Stage 2 registers the table lookup of stage 1.
- STAGES=1: lookup is combinational from in_data into a single output register.
- Each stage holds a valid bit v[k]. Ready chain:
  - rdy[last] = out_ready || !v[last]
  - rdy[k] = rdy[k+1] || !v[k]
  - in_ready = rdy[0]
- A stage loads when its ready is high.
  - Its valid becomes the upstream valid (for stage 0, in_valid && in_ready).
  - Its data and mode register load only when the upstream valid is 1. A bubble keeps the old data and clears valid.
- Stalled stages hold data and mode unchanged. No beat is dropped or duplicated.
- Beats leave in acceptance order. Mixed forward/inverse beats may be interleaved freely.
- out_valid, out_data and out_inv come directly from the last stage's registers. No combinational path from in_* to out_*.
- in_ready is combinational from out_ready and the stage valids.

## Timing
- Reset (rst_n low, asynchronous):
  - all v[k] = 0, out_valid = 0, out_data = 0, out_inv = 0, internal data registers = 0.
  - in_ready therefore reads 1 during and after reset.
- Latency: a beat accepted at edge N appears as out_valid=1 after edge N+STAGES-1. It is consumable at edge N+STAGES when out_ready=1.
- Throughput: one beat per cycle while out_ready stays 1.
- Full: with out_ready=0, the pipe fills with STAGES beats. in_ready then drops to 0 in the cycle all v[k]=1.
- Simultaneous pop and push on a full pipe: the beat is accepted that same cycle (in_ready=1), with no bubble.
- Empty pipe with in_valid=0: out_valid stays 0 and out_data holds its last value.
- Reset asserted mid-stream: all in-flight beats are discarded at once. No output appears after reset releases until new beats are accepted.
- in_data and in_inv must be stable while in_valid=1 and in_ready=0. Behaviour otherwise is undefined for that beat only.

## Structure
- Package aes_sbox_pkg:
  - SBOX and INV_SBOX as 256×8 constant arrays
  - functions sbox_fwd(byte), sbox_inv(byte)
  - localparam bounds for LANES and STAGES
- Sub-module aes_sbox_lane: one byte, combinational, inputs byte and inv, output byte. Instantiated LANES times with a generate loop.
- Pipeline valid/ready control is implemented once in aes_sbox_array. Data registers are a LANES-wide vector.
- Elaboration error if STAGES∉{1,2} or LANES∉[1,32].

## Test plan
- Reset then idle, LANES=16, STAGES=2: in_ready=1, out_valid=0, out_data=0 throughout. Assert rst_n low mid-idle and see no glitch on outputs.
- Forward single beat:
  - Stimulus: in_data lanes = 00,01,53,ff,… with in_inv=0 at edge N.
  - Expected: out lanes = 63,7c,ed,16, out_inv=0, out_valid rising after edge N+1.
- Inverse round-trip:
  - Stimulus: feed each of the 256 bytes forward, then feed the outputs back inverse (e.g. 63→00, ed→53, 16→ff).
  - Expected: every original byte is recovered. Lane order is checked with distinct values per lane.
- Back-pressure:
  - Stimulus: stream 8 beats alternating in_inv with out_ready held 0 for 5 cycles.
  - Expected: in_ready=0 once 2 beats are held. After release, all 8 beats emerge in order, each with its matching out_inv, none lost or duplicated.
- Full throughput with simultaneous push/pop:
  - Stimulus: out_ready=1 constant, 100 random beats.
  - Expected: 100 outputs in 101 cycles (STAGES=2) and in 100 cycles (STAGES=1), all matching the reference-model table.
- Reset mid-operation:
  - Stimulus: pipe full and stalled, then pulse rst_n low for 1 cycle.
  - Expected: out_valid=0 immediately (async). After release, no stale beat appears and the next accepted beat emerges with normal latency.
